pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic pipeline register between adjacent CPU stages.
// Carries a DATA_W-bit payload with a valid/ready handshake. It supports a
// synchronous flush to FLUSH_DATA and an optional two-entry skid buffer. The
// skid buffer gives a registered o_ready with no combinational path from i_ready.
//
// Parameters:
//   DATA_W     payload width
//   RESET_DATA o_data (and skid data) after reset
//   FLUSH_DATA o_data loaded on flush
//   SKID       1 = two-entry skid buffer, registered o_ready
//              0 = single register, combinational o_ready
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), async active-low reset
//   i_valid/o_ready  upstream handshake, i_data payload in
//   o_valid/i_ready  downstream handshake, o_data payload out
//   i_flush          synchronous kill of all held entries
//   o_stall_cnt      16-bit saturating count of cycles with o_valid & ~i_ready
//                    (present only when PIPE_STAGE_STALL_CNT_EN is defined)
module pipe_stage_reg #(
    parameter int unsigned          DATA_W     = 96,
    parameter logic [DATA_W-1:0]    RESET_DATA = DATA_W'({32'h00000013, 64'h0}),
    parameter logic [DATA_W-1:0]    FLUSH_DATA = DATA_W'({32'h00000013, 64'h0}),
    parameter int unsigned          SKID       = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    // State encoding is {main valid, skid valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    if (SKID != 0) begin : g_skid
        state_t              r_state;
        state_t              w_state_nxt;
        logic [DATA_W-1:0]   r_main;
        logic [DATA_W-1:0]   r_skid;
        logic [DATA_W-1:0]   w_main_nxt;
        logic [DATA_W-1:0]   w_skid_nxt;
        logic                r_ready;
        logic                w_it;
        logic                w_ot;

        assign w_it    = i_valid & r_ready;
        assign w_ot    = (r_state != ST_EMPTY) & i_ready;
        assign o_valid = (r_state != ST_EMPTY);
        assign o_ready = r_ready;
        assign o_data  = r_main;

        // State and payload registers.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state <= ST_EMPTY;
                r_main  <= RESET_DATA;
                r_skid  <= RESET_DATA;
                r_ready <= 1'b1;
            end else begin
                r_state <= w_state_nxt;
                r_main  <= w_main_nxt;
                r_skid  <= w_skid_nxt;
                // Registered ready: accept next cycle unless the skid slot fills.
                r_ready <= (w_state_nxt != ST_FULL);
            end
        end

        // Next-state and payload steering; flush overrides every transition.
        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
            case (r_state)
                ST_EMPTY: begin
                    if (w_it) begin
                        w_main_nxt  = i_data;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_ot && w_it) begin
                        w_main_nxt = i_data;
                    end else if (w_ot) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_it) begin
                        w_skid_nxt  = i_data;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Skid entry is older than any new input, so it moves up first.
                    if (w_ot) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
            if (i_flush) begin
                w_state_nxt = ST_EMPTY;
                w_main_nxt  = FLUSH_DATA;
            end
        end
    end else begin : g_noskid
        logic                r_valid;
        logic [DATA_W-1:0]   r_data;

        assign o_ready = i_ready | ~r_valid;
        assign o_valid = r_valid;
        assign o_data  = r_data;

        // Single register: loads whenever empty or being drained this cycle.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= 1'b0;
                r_data  <= RESET_DATA;
            end else if (i_flush) begin
                r_valid <= 1'b0;
                r_data  <= FLUSH_DATA;
            end else if (!r_valid || i_ready) begin
                r_valid <= i_valid;
                if (i_valid) begin
                    r_data <= i_data;
                end
            end
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    assign o_stall_cnt = r_stall_cnt;

    // Saturating stall counter; only reset clears it, flush does not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 16'h0;
        end else if (o_valid && !i_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 0 has SKID=0 and instance 1 has SKID=1.
// Both instances are checked against a queue-level model on every cycle. Directed
// literal checks cover reset, streaming, back-pressure and flush.
module tb_pipe_stage_reg;

    localparam int unsigned    DW      = 96;
    localparam logic [DW-1:0]  NOP     = {32'h00000013, 64'h0};
    localparam logic [DW-1:0]  FLUSH_V = {32'h00000013, 64'h0000_0000_0000_DEAD};

    logic            clk;
    logic            rst_n;
    logic            vld  [2];
    logic            rdy  [2];
    logic            fl   [2];
    logic [DW-1:0]   dat  [2];
    logic            ov   [2];
    logic            ordy [2];
    logic [DW-1:0]   od   [2];
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0]     scnt [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per-instance FIFO of held entries (capacity 2 for SKID=1, 1 for SKID=0).
    logic [DW-1:0]   mbuf  [2][2];
    int              mcnt  [2];
    logic [DW-1:0]   mlast [2];
    int              mstall[2];

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(NOP), .FLUSH_DATA(FLUSH_V), .SKID(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(ordy[0]), .i_data(dat[0]),
        .o_valid(ov[0]), .i_ready(rdy[0]), .o_data(od[0]), .i_flush(fl[0])
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .o_stall_cnt(scnt[0])
`endif
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(NOP), .FLUSH_DATA(FLUSH_V), .SKID(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(ordy[1]), .i_data(dat[1]),
        .o_valid(ov[1]), .i_ready(rdy[1]), .o_data(od[1]), .i_flush(fl[1])
`ifdef PIPE_STAGE_STALL_CNT_EN
        , .o_stall_cnt(scnt[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int d, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp_v);
        n_tests = n_tests + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s dut%0d: got %h, want %h at %0t", nm, d, act, exp_v, $time);
        end
    endtask

    // SKID=1: ready means room in the two-entry store. SKID=0: ready means empty or draining now.
    function automatic logic mready(input int k);
        if (k == 1) return (mcnt[1] < 2);
        return rdy[0] | (mcnt[0] == 0);
    endfunction

    function automatic logic [DW-1:0] mdata(input int k);
        return (mcnt[k] > 0) ? mbuf[k][0] : mlast[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]   = 0;
            mlast[k]  = NOP;
            mstall[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_step();
        logic it;
        logic ot;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            it = vld[k] & mready(k);
            ot = (mcnt[k] > 0) & rdy[k];
            if ((mcnt[k] > 0) && !rdy[k] && (mstall[k] < 65535)) mstall[k] = mstall[k] + 1;
            if (fl[k]) begin
                mcnt[k]  = 0;
                mlast[k] = FLUSH_V;
            end else begin
                if (ot) begin
                    mlast[k]   = mbuf[k][0];
                    mbuf[k][0] = mbuf[k][1];
                    mcnt[k]    = mcnt[k] - 1;
                end
                if (it) begin
                    mbuf[k][mcnt[k]] = dat[k];
                    mcnt[k]          = mcnt[k] + 1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    chk("model_valid", k, DW'(ov[k]), DW'(mcnt[k] > 0));
                    chk("model_ready", k, DW'(ordy[k]), DW'(mready(k)));
                    chk("model_data", k, od[k], mdata(k));
`ifdef PIPE_STAGE_STALL_CNT_EN
                    chk("model_stall", k, DW'(scnt[k]), DW'(mstall[k]));
`endif
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b1;
            rdy[k] = 1'b1;
            fl[k]  = 1'b0;
            dat[k] = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
        end
        repeat (2) cyc();
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, DW'(ov[k]), DW'(1'b0));
            chk("rst_data", k, od[k], 96'h00000013_0000000000000000);
            chk("rst_ready", k, DW'(ordy[k]), DW'(1'b1));
        end
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("pre_async_valid", 1, DW'(ov[1]), DW'(1'b1));
        // Asynchronous reset in the middle of a cycle while holding data.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_valid", k, DW'(ov[k]), DW'(1'b0));
            chk("async_rst_data", k, od[k], 96'h00000013_0000000000000000);
            chk("async_rst_ready", k, DW'(ordy[k]), DW'(1'b1));
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Streaming 1..8 through both instances.
        for (int i = 1; i <= 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                vld[k] = 1'b1;
                dat[k] = DW'(i);
            end
            cyc();
            for (int k = 0; k < 2; k++) begin
                chk("stream_data", k, od[k], DW'(i));
                chk("stream_valid", k, DW'(ov[k]), DW'(1'b1));
                chk("stream_ready", k, DW'(ordy[k]), DW'(1'b1));
            end
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk("drain_valid", k, DW'(ov[k]), DW'(1'b0));
            chk("drain_hold", k, od[k], DW'(8));
        end

        // Back-pressure with skid buffer: A in main, B into skid, C held upstream.
        vld[1] = 1'b1; dat[1] = 96'hA; rdy[1] = 1'b1;
        cyc();
        chk("bp1_a", 1, od[1], 96'hA);
        rdy[1] = 1'b0; dat[1] = 96'hB;
        cyc();
        chk("bp1_full_ready", 1, DW'(ordy[1]), DW'(1'b0));
        chk("bp1_full_data", 1, od[1], 96'hA);
        dat[1] = 96'hC;
        cyc();
        chk("bp1_hold_data", 1, od[1], 96'hA);
        chk("bp1_hold_ready", 1, DW'(ordy[1]), DW'(1'b0));
        rdy[1] = 1'b1;
        cyc();
        chk("bp1_b", 1, od[1], 96'hB);
        chk("bp1_ready_back", 1, DW'(ordy[1]), DW'(1'b1));
        cyc();
        chk("bp1_c", 1, od[1], 96'hC);
        vld[1] = 1'b0;
        cyc();
        chk("bp1_empty", 1, DW'(ov[1]), DW'(1'b0));

        // Back-pressure without skid: o_ready follows i_ready in the same cycle.
        vld[0] = 1'b1; dat[0] = 96'hA; rdy[0] = 1'b1;
        cyc();
        chk("bp0_a", 0, od[0], 96'hA);
        rdy[0] = 1'b0; dat[0] = 96'hB;
        #1;
        chk("bp0_ready_lo", 0, DW'(ordy[0]), DW'(1'b0));
        cyc();
        chk("bp0_hold_a", 0, od[0], 96'hA);
        rdy[0] = 1'b1;
        #1;
        chk("bp0_ready_hi", 0, DW'(ordy[0]), DW'(1'b1));
        cyc();
        chk("bp0_b", 0, od[0], 96'hB);
        rdy[0] = 1'b0; dat[0] = 96'hC;
        #1;
        chk("bp0_ready_lo2", 0, DW'(ordy[0]), DW'(1'b0));
        cyc();
        chk("bp0_hold_b", 0, od[0], 96'hB);
        rdy[0] = 1'b1;
        cyc();
        chk("bp0_c", 0, od[0], 96'hC);
        vld[0] = 1'b0;
        cyc();
        chk("bp0_empty", 0, DW'(ov[0]), DW'(1'b0));

        // Flush while FULL, with D presented alongside the flush.
        vld[1] = 1'b1; dat[1] = 96'hA; rdy[1] = 1'b0;
        cyc();
        dat[1] = 96'hB;
        cyc();
        chk("fl_full_ready", 1, DW'(ordy[1]), DW'(1'b0));
        fl[1] = 1'b1; dat[1] = 96'hD;
        cyc();
        chk("fl_valid", 1, DW'(ov[1]), DW'(1'b0));
        chk("fl_ready", 1, DW'(ordy[1]), DW'(1'b1));
        chk("fl_data", 1, od[1], FLUSH_V);
        fl[1] = 1'b0; vld[1] = 1'b0; rdy[1] = 1'b1;
        repeat (3) cyc();
        chk("fl_no_d_data", 1, od[1], FLUSH_V);
        chk("fl_no_d_valid", 1, DW'(ov[1]), DW'(1'b0));

        // Flush together with a valid input on the single-register instance drops the input.
        fl[0] = 1'b1; vld[0] = 1'b1; dat[0] = 96'hD;
        cyc();
        chk("fl0_valid", 0, DW'(ov[0]), DW'(1'b0));
        chk("fl0_data", 0, od[0], FLUSH_V);
        fl[0] = 1'b0; vld[0] = 1'b0;
        cyc();
        chk("fl0_dropped", 0, DW'(ov[0]), DW'(1'b0));

`ifdef PIPE_STAGE_STALL_CNT_EN
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("stall_rst", 1, DW'(scnt[1]), DW'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        vld[1] = 1'b1; dat[1] = 96'hE; rdy[1] = 1'b1;
        cyc();
        vld[1] = 1'b0; rdy[1] = 1'b0;
        repeat (5) cyc();
        chk("stall_5", 1, DW'(scnt[1]), DW'(5));
        fl[1] = 1'b1; rdy[1] = 1'b1;
        cyc();
        chk("stall_flush_keep", 1, DW'(scnt[1]), DW'(5));
        fl[1] = 1'b0; vld[1] = 1'b1; dat[1] = 96'hF;
        cyc();
        vld[1] = 1'b0; rdy[1] = 1'b0;
        repeat (65540) cyc();
        chk("stall_sat", 1, DW'(scnt[1]), DW'(16'hFFFF));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("stall_rst2", 1, DW'(scnt[1]), DW'(0));
        cyc();
        rst_n = 1'b1;
        rdy[1] = 1'b1;
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
